// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 SCCB register loader.
// OV7670_RESET_DELAY_EN adds the SETTLE state used after a COM7 soft reset.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_BITS,
        ST_STOP,
        ST_GAP
`ifdef OV7670_RESET_DELAY_EN
        , ST_SETTLE
`endif
    } sccb_state_e;

    localparam logic [7:0]  COM7_ADDR      = 8'h12;
    localparam int unsigned COM7_RESET_BIT = 7;
    localparam int unsigned FRAME_BITS     = 27;
    localparam int unsigned QTR_W          = 2;
    localparam int unsigned BIT_W          = 5;
    localparam int unsigned GAP_QUARTERS   = 8;

    // ACK slots follow each byte: bit indices 8, 17 and 26 counted from the MSB.
    function automatic logic is_dont_care(input logic [BIT_W-1:0] idx);
        return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
    endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick generator: one-clock tick every DIV clocks while enabled.
module sccb_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    output logic tick
);

    localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ov7670_sccb_master.sv
// Streams {register, value} commands from a ROM to the OV7670 over write-only SCCB.
// OV7670_RESET_DELAY_EN inserts a settle delay after a COM7 soft-reset write.
module ov7670_sccb_master
    import ov7670_pkg::*;
#(
    parameter int unsigned CLK_HZ            = 100_000_000,
    parameter int unsigned SCCB_HZ           = 100_000,
    parameter logic [7:0]  DEV_ADDR          = 8'h42,
    parameter int unsigned RESET_WAIT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        advance,
    output logic        sioc,
    output logic        siod_out,
    output logic        siod_oe,
    output logic        config_done
);

    localparam int unsigned DIV_RAW = CLK_HZ / (4 * SCCB_HZ);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'(GAP_QUARTERS / 4 - 1);
    localparam logic [QTR_W-1:0] Q_LAST    = QTR_W'(3);

    sccb_state_e            state, state_d;
    logic [QTR_W-1:0]       qtr, qtr_d;
    logic [BIT_W-1:0]       bit_idx, bit_idx_d;
    logic [FRAME_BITS-1:0]  frame;
    logic                   sioc_d, siod_out_d, siod_oe_d, advance_d, config_done_d;
    logic                   tick, tick_en;

`ifdef OV7670_RESET_DELAY_EN
    localparam logic [31:0] SETTLE_LAST =
        (RESET_WAIT_CYCLES == 0) ? 32'd0 : 32'(RESET_WAIT_CYCLES - 1);
    logic [31:0] settle_cnt, settle_cnt_d;
    logic        settle_req;

    assign settle_req = (frame[17:10] == COM7_ADDR) && frame[1 + COM7_RESET_BIT];
`else
    // Parameter retained so both builds share one instantiation interface.
    logic unused_reset_wait;
    assign unused_reset_wait = ^32'(RESET_WAIT_CYCLES);
`endif

    assign tick_en = (state == ST_LOAD) || (state == ST_START) || (state == ST_BITS) ||
                     (state == ST_STOP) || (state == ST_GAP);

    sccb_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .enable (tick_en),
        .tick   (tick)
    );

    // State, counters and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            qtr         <= '0;
            bit_idx     <= '0;
            frame       <= '0;
            sioc        <= 1'b1;
            siod_out    <= 1'b1;
            siod_oe     <= 1'b0;
            advance     <= 1'b0;
            config_done <= 1'b0;
`ifdef OV7670_RESET_DELAY_EN
            settle_cnt  <= '0;
`endif
        end else begin
            state       <= state_d;
            qtr         <= qtr_d;
            bit_idx     <= bit_idx_d;
            sioc        <= sioc_d;
            siod_out    <= siod_out_d;
            siod_oe     <= siod_oe_d;
            advance     <= advance_d;
            config_done <= config_done_d;
`ifdef OV7670_RESET_DELAY_EN
            settle_cnt  <= settle_cnt_d;
`endif
            if (state == ST_LOAD) begin
                frame <= {DEV_ADDR, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
            end
        end
    end

    // Next-state logic; outputs are decoded from the next state so they align with it.
    always_comb begin
        state_d       = state;
        qtr_d         = qtr;
        bit_idx_d     = bit_idx;
        advance_d     = 1'b0;
        config_done_d = (state == ST_IDLE) && finished;
`ifdef OV7670_RESET_DELAY_EN
        settle_cnt_d  = settle_cnt;
`endif

        case (state)
            ST_IDLE: begin
                if (!finished) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d   = ST_START;
                qtr_d     = '0;
                bit_idx_d = '0;
            end
            ST_START: begin
                if (tick) begin
                    qtr_d = qtr + QTR_W'(1);
                    if (qtr == Q_LAST) state_d = ST_BITS;
                end
            end
            ST_BITS: begin
                if (tick) begin
                    qtr_d = qtr + QTR_W'(1);
                    if (qtr == Q_LAST) begin
                        if (bit_idx == LAST_BIT) begin
                            state_d   = ST_STOP;
                            bit_idx_d = '0;
                        end else begin
                            bit_idx_d = bit_idx + BIT_W'(1);
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    qtr_d = qtr + QTR_W'(1);
                    if (qtr == QTR_W'(2)) advance_d = 1'b1;
                    if (qtr == Q_LAST) begin
                        bit_idx_d = '0;
`ifdef OV7670_RESET_DELAY_EN
                        if (settle_req) begin
                            state_d      = ST_SETTLE;
                            settle_cnt_d = '0;
                        end else begin
                            state_d = ST_GAP;
                        end
`else
                        state_d = ST_GAP;
`endif
                    end
                end
            end
            ST_GAP: begin
                // bit_idx counts groups of four quarters here.
                if (tick) begin
                    qtr_d = qtr + QTR_W'(1);
                    if (qtr == Q_LAST) begin
                        if (bit_idx == GAP_LAST) begin
                            state_d   = ST_IDLE;
                            bit_idx_d = '0;
                        end else begin
                            bit_idx_d = bit_idx + BIT_W'(1);
                        end
                    end
                end
            end
`ifdef OV7670_RESET_DELAY_EN
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_d   = ST_GAP;
                    qtr_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt + 32'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        sioc_d     = 1'b1;
        siod_out_d = 1'b1;
        siod_oe_d  = 1'b0;
        case (state_d)
            ST_START: begin
                siod_oe_d  = 1'b1;
                siod_out_d = (qtr_d == QTR_W'(0));
                sioc_d     = (qtr_d != Q_LAST);
            end
            ST_BITS: begin
                sioc_d     = (qtr_d == QTR_W'(1)) || (qtr_d == QTR_W'(2));
                siod_oe_d  = !is_dont_care(bit_idx_d);
                siod_out_d = siod_oe_d ? frame[LAST_BIT - bit_idx_d] : 1'b1;
            end
            ST_STOP: begin
                sioc_d     = (qtr_d != QTR_W'(0));
                siod_oe_d  = (qtr_d != Q_LAST);
                siod_out_d = (qtr_d == Q_LAST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ov7670_sccb_master.sv
// Scoreboard bench: stimulus queues expected frames, a bus monitor decodes SCCB and compares.
module tb_ov7670_sccb_master;

    localparam int unsigned CLK_HZ  = 16_000_000;
    localparam int unsigned SCCB_HZ = 1_000_000;
    localparam int unsigned RWC     = 200;
    localparam int unsigned GAP_SPACING = 42;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] command;
    logic        finished, advance, sioc, siod_out, siod_oe, config_done;

    always #5 clk = ~clk;

    ov7670_sccb_master #(
        .CLK_HZ(CLK_HZ), .SCCB_HZ(SCCB_HZ), .DEV_ADDR(8'h42), .RESET_WAIT_CYCLES(RWC)
    ) dut (
        .clk(clk), .resetn(resetn), .command(command), .finished(finished),
        .advance(advance), .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe),
        .config_done(config_done)
    );

    // ROM model with one-cycle registered output.
    logic [15:0] rom [0:63];
    int unsigned rom_addr;
    logic        rom_rst = 1'b1;

    always @(posedge clk) begin
        if (rom_rst) begin
            rom_addr <= 0;
            command  <= 16'hFFFF;
        end else begin
            if (advance) rom_addr <= rom_addr + 1;
            command <= rom[rom_addr[5:0]];
        end
    end
    assign finished = (command == 16'hFFFF);

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor state.
    logic        p_sioc = 1'b1, p_line = 1'b1, p_adv = 1'b0, line;
    logic        in_frame = 1'b0;
    logic [26:0] m_bits, m_z;
    int          mon_cnt = 0, frames = 0, adv_cnt = 0, cyc = 0;
    int          start_cyc[$], stop_cyc[$];

    task automatic score_frame();
        logic [15:0] e;
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_bits", 32'(mon_cnt), 32'd27);
            check("frame_dev", 32'(m_bits[26:19]), 32'h42);
            check("frame_reg", 32'(m_bits[17:10]), 32'(e[15:8]));
            check("frame_val", 32'(m_bits[8:1]), 32'(e[7:0]));
            check("frame_zmask", 32'(m_z), 32'h0040201);
        end
    endtask

    always @(negedge clk) begin
        line = siod_oe ? siod_out : 1'b1;
        cyc++;
        if (!resetn) begin
            in_frame = 1'b0;
        end else begin
            if (p_sioc && sioc && p_line && !line) begin
                in_frame = 1'b1;
                mon_cnt  = 0;
                m_bits   = '0;
                m_z      = '0;
                start_cyc.push_back(cyc);
            end else if (p_sioc && sioc && !p_line && line) begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    stop_cyc.push_back(cyc);
                    frames++;
                    score_frame();
                end
            end else if (!p_sioc && sioc && in_frame && mon_cnt < 27) begin
                m_bits[26 - mon_cnt] = line;
                m_z[26 - mon_cnt]    = !siod_oe;
                mon_cnt++;
            end
            if (p_adv) check("advance_width", 32'(advance), 32'd0);
            if (advance && !p_adv) adv_cnt++;
        end
        p_sioc = sioc;
        p_line = line;
        p_adv  = advance;
    end

    task automatic clear_stats();
        frames = 0;
        adv_cnt = 0;
        start_cyc.delete();
        stop_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rom_rst = 1'b1;
        resetn  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rom_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (config_done !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(config_done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad_sioc, bad_oe;
        int sp;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_sioc", 32'(sioc), 32'd1);
        check("rst_siod_out", 32'(siod_out), 32'd1);
        check("rst_siod_oe", 32'(siod_oe), 32'd0);
        check("rst_advance", 32'(advance), 32'd0);
        check("rst_config_done", 32'(config_done), 32'd0);

        // Single entry 0x3A04.
        clear_stats();
        rom[0] = 16'h3A04; rom[1] = 16'hFFFF;
        exp_q.push_back(16'h3A04);
        do_reset();
        wait_done(3000, "t1_done");
        check("t1_frames", 32'(frames), 32'd1);
        check("t1_advances", 32'(adv_cnt), 32'd1);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Empty table: bus must stay idle.
        clear_stats();
        rom[0] = 16'hFFFF;
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        check("t2_done_2clk", 32'(config_done), 32'd1);
        bad_sioc = 0; bad_oe = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (sioc !== 1'b1) bad_sioc++;
            if (siod_oe !== 1'b0) bad_oe++;
        end
        check("t2_sioc_high", 32'(bad_sioc), 32'd0);
        check("t2_oe_low", 32'(bad_oe), 32'd0);
        check("t2_no_advance", 32'(adv_cnt), 32'd0);
        check("t2_no_frames", 32'(frames), 32'd0);

        // Full 56-entry table.
        clear_stats();
        for (int i = 0; i < 56; i++) begin
            rom[i] = {8'(i + 1), 8'(8'hA5 ^ 8'(i * 7))};
            exp_q.push_back(rom[i]);
        end
        rom[56] = 16'hFFFF;
        do_reset();
        wait_done(40000, "t3_done");
        check("t3_frames", 32'(frames), 32'd56);
        check("t3_advances", 32'(adv_cnt), 32'd56);
        check("t3_rom_addr", 32'(rom_addr), 32'd56);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset pulse during bit 12 of the first frame.
        clear_stats();
        rom[0] = 16'h1C7F; rom[1] = 16'h3A04; rom[2] = 16'hFFFF;
        exp_q.push_back(16'h1C7F);
        exp_q.push_back(16'h3A04);
        do_reset();
        n = 0;
        while (!(in_frame && mon_cnt == 12) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t4_reached_bit12", 32'(in_frame && mon_cnt == 12), 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("t4_abort_sioc", 32'(sioc), 32'd1);
        check("t4_abort_oe", 32'(siod_oe), 32'd0);
        resetn = 1'b1;
        wait_done(4000, "t4_done");
        check("t4_frames", 32'(frames), 32'd2);
        check("t4_advances", 32'(adv_cnt), 32'd2);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // COM7 soft reset followed by normal entries: inter-frame spacing.
        clear_stats();
        rom[0] = 16'h1280; rom[1] = 16'h3A04; rom[2] = 16'h1C7F; rom[3] = 16'hFFFF;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h3A04);
        exp_q.push_back(16'h1C7F);
        do_reset();
        wait_done(6000, "t5_done");
        check("t5_starts", 32'(start_cyc.size()), 32'd3);
        check("t5_stops", 32'(stop_cyc.size()), 32'd3);
        if (start_cyc.size() == 3 && stop_cyc.size() == 3) begin
            sp = start_cyc[1] - stop_cyc[0];
`ifdef OV7670_RESET_DELAY_EN
            check("t5_settle_spacing", 32'(sp >= int'(RWC)), 32'd1);
`else
            check("t5_com7_spacing", 32'(sp), 32'(GAP_SPACING));
`endif
            sp = start_cyc[2] - stop_cyc[1];
            check("t5_normal_spacing", 32'(sp), 32'(GAP_SPACING));
        end
        check("t5_advances", 32'(adv_cnt), 32'd3);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
